// File: rtl/uart_tx_fifo.sv
// RS-232 transmitter with a transmit FIFO in front of it. Words are queued on a
// valid/ready port and sent LSB-first with optional parity and one or two stop bits.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbgState
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } stateT;

  // Write port: a word moves when wr_valid and wr_ready are both high at a
  // rising clk edge; wr_ready depends only on the current fill level.

  stateT                 state;
  logic [CW-1:0]         baudCnt;
  logic [3:0]            bitIdx;
  logic [DATA_BITS-1:0]  shiftReg;
  logic                  parityBit;
  logic                  txdNext;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic [AW:0]           count;
  logic [DATA_BITS-1:0]  headWord;
  logic                  headParity;

  logic push;
  logic pop;
  logic tick;
  logic lastStop;

  assign wr_ready   = (count != DEPTH);
  assign fifo_count = count;
  assign dbgState   = state;

  assign push     = wr_valid & wr_ready;
  assign tick     = (baudCnt == DIV_LAST);
  assign lastStop = (bitIdx == STOP_LAST);
  // Pops happen either from idle or exactly on the last stop-bit tick, which
  // is what makes consecutive frames abut with no idle gap.
  assign pop      = (count != '0) &&
                    ((state == S_IDLE) || ((state == S_STOP) && tick && lastStop));

  always_comb begin
    headWord   = mem[rdPtr];
    headParity = (PARITY == 2) ? (^headWord) : (~^headWord);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    txdNext = 1'b1;
    case (state)
      S_START:  txdNext = 1'b0;
      S_DATA:   txdNext = shiftReg[0];
      S_PARITY: txdNext = parityBit;
      default:  txdNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baudCnt   <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
    end else begin
      txd  <= txdNext;
      // Registered one cycle behind the state so it drops together with the
      // end of the last stop bit on the line.
      busy <= (state != S_IDLE) || (count != '0) || push;

      if ((state == S_IDLE) || tick || pop) begin
        baudCnt <= '0;
      end else begin
        baudCnt <= baudCnt + CW'(1);
      end

      case (state)
        S_IDLE: begin
          bitIdx <= '0;
          if (pop) begin
            shiftReg  <= headWord;
            parityBit <= headParity;
            state     <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            bitIdx <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            shiftReg <= shiftReg >> 1;
            if (bitIdx == DATA_LAST) begin
              bitIdx <= '0;
              state  <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bitIdx <= bitIdx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            bitIdx <= '0;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (lastStop) begin
              bitIdx <= '0;
              if (pop) begin
                shiftReg  <= headWord;
                parityBit <= headParity;
                state     <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bitIdx <= bitIdx + 4'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (8N1, 8O1, 8E1, 7N2) at DIV=10,
// line waveform checked bit by bit against hand-built frames.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] wrValid;
  logic [8:0] wrData [4];
  logic [3:0] wrReady;
  logic [3:0] txdW;
  logic [3:0] busyW;
  logic [4:0] cnt0, cnt1, cnt2, cnt3;
  logic [2:0] dbg0, dbg1, dbg2, dbg3;

  int passCnt  = 0;
  int totalCnt = 0;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000)) u8n1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wrValid[0]), .wr_ready(wrReady[0]),
    .wr_data(wrData[0][7:0]), .txd(txdW[0]), .busy(busyW[0]),
    .fifo_count(cnt0), .dbgState(dbg0));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(1)) u8o1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wrValid[1]), .wr_ready(wrReady[1]),
    .wr_data(wrData[1][7:0]), .txd(txdW[1]), .busy(busyW[1]),
    .fifo_count(cnt1), .dbgState(dbg1));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(2)) u8e1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wrValid[2]), .wr_ready(wrReady[2]),
    .wr_data(wrData[2][7:0]), .txd(txdW[2]), .busy(busyW[2]),
    .fifo_count(cnt2), .dbgState(dbg2));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .STOP_BITS(2)) u7n2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wrValid[3]), .wr_ready(wrReady[3]),
    .wr_data(wrData[3][6:0]), .txd(txdW[3]), .busy(busyW[3]),
    .fifo_count(cnt3), .dbgState(dbg3));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt = totalCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame bit 0 is the start bit; data LSB first, then parity, then stops.
  function automatic logic [15:0] mkFrame(input logic [8:0] d, input int nd,
                                          input int hasPar, input logic pb, input int ns);
    logic [15:0] f;
    int p;
    f = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      f[p] = d[i];
      p++;
    end
    if (hasPar != 0) begin
      f[p] = pb;
      p++;
    end
    for (int i = 0; i < ns; i++) begin
      f[p] = 1'b1;
      p++;
    end
    return f;
  endfunction

  function automatic logic [8:0] burstWord(input int i);
    return 9'((i * 37 + 27) & 255);
  endfunction

  // Called at a negedge; returns 1ns after the accepting edge.
  task automatic push(input int idx, input logic [8:0] d);
    wrValid[idx] = 1'b1;
    wrData[idx]  = d;
    @(posedge clk);
    #1;
    wrValid[idx] = 1'b0;
  endtask

  // Each bit must hold for all 10 consecutive negedge samples.
  task automatic checkWave(input int idx, input logic [15:0] frame, input int nbits,
                           input string tag);
    for (int b = 0; b < nbits; b++) begin
      int m;
      m = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (txdW[idx] === frame[b]) m++;
      end
      chk($sformatf("%s bit%0d cycles", tag, b), 16'(m), 16'd10);
    end
  endtask

  task automatic sendCheck(input int idx, input logic [8:0] d, input logic [15:0] frame,
                           input int nbits, input string tag);
    push(idx, d);
    @(posedge clk);
    @(posedge clk);
    checkWave(idx, frame, nbits, tag);
    @(negedge clk);
    chk({tag, " busy after frame"}, 16'(busyW[idx]), 16'd0);
    chk({tag, " txd idle"}, 16'(txdW[idx]), 16'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    wrValid = '0;
    for (int i = 0; i < 4; i++) wrData[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset txd", 16'(txdW[0]), 16'd1);
    chk("reset busy", 16'(busyW[0]), 16'd0);
    chk("reset count", 16'(cnt0), 16'd0);
    chk("reset ready", 16'(wrReady[0]), 16'd1);
    chk("reset state", 16'(dbg0), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0x55 with exact latency
    push(0, 9'h055);
    @(negedge clk);
    chk("t1 busy after push", 16'(busyW[0]), 16'd1);
    chk("t1 count after push", 16'(cnt0), 16'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t1 count after pop", 16'(cnt0), 16'd0);
    chk("t1 txd before start", 16'(txdW[0]), 16'd1);
    chk("t1 state start", 16'(dbg0), 16'd1);
    @(posedge clk);
    checkWave(0, mkFrame(9'h055, 8, 0, 1'b0, 1), 10, "t1");
    @(negedge clk);
    chk("t1 busy after frame", 16'(busyW[0]), 16'd0);
    chk("t1 txd idle", 16'(txdW[0]), 16'd1);

    // parity: 0x07 has three ones
    sendCheck(1, 9'h007, mkFrame(9'h007, 8, 1, 1'b0, 1), 11, "t2 odd");
    sendCheck(2, 9'h007, mkFrame(9'h007, 8, 1, 1'b1, 1), 11, "t2 even");

    // 7 data bits, 2 stop bits
    sendCheck(3, 9'h041, mkFrame(9'h041, 7, 0, 1'b0, 2), 10, "t3 7n2");

    // 17-word burst, back-to-back frames
    fork
      begin
        wrValid[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
          wrData[0] = burstWord(i);
          @(posedge clk);
          #1;
        end
        wrValid[0] = 1'b0;
        @(negedge clk);
        chk("t4 count full", 16'(cnt0), 16'd16);
        chk("t4 ready low when full", 16'(wrReady[0]), 16'd0);
        repeat (134) @(negedge clk);
        chk("t4 count after pop", 16'(cnt0), 16'd15);
        chk("t4 ready after pop", 16'(wrReady[0]), 16'd1);
      end
      begin
        repeat (3) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
          checkWave(0, mkFrame(burstWord(i), 8, 0, 1'b0, 1), 10, $sformatf("t4 frame%0d", i));
        end
      end
    join
    @(negedge clk);
    chk("t4 busy after burst", 16'(busyW[0]), 16'd0);

    // push and pop on the same edge at a frame boundary
    push(0, 9'h0C3);
    push(0, 9'h011);
    push(0, 9'h0F0);
    push(0, 9'h09A);
    repeat (97) @(posedge clk);
    @(negedge clk);
    chk("t5 count before boundary", 16'(cnt0), 16'd3);
    chk("t5 state stop", 16'(dbg0), 16'd4);
    wrValid[0] = 1'b1;
    wrData[0]  = 9'h03C;
    @(posedge clk);
    #1;
    wrValid[0] = 1'b0;
    @(negedge clk);
    chk("t5 count after push+pop", 16'(cnt0), 16'd3);
    chk("t5 state restart", 16'(dbg0), 16'd1);
    checkWave(0, mkFrame(9'h011, 8, 0, 1'b0, 1), 10, "t5 b");
    checkWave(0, mkFrame(9'h0F0, 8, 0, 1'b0, 1), 10, "t5 c");
    checkWave(0, mkFrame(9'h09A, 8, 0, 1'b0, 1), 10, "t5 d");
    checkWave(0, mkFrame(9'h03C, 8, 0, 1'b0, 1), 10, "t5 e");
    @(negedge clk);
    chk("t5 busy after drain", 16'(busyW[0]), 16'd0);

    // reset in the middle of a data bit of frame 2
    push(0, 9'h0FF);
    push(0, 9'h000);
    push(0, 9'h012);
    push(0, 9'h034);
    push(0, 9'h056);
    push(0, 9'h078);
    repeat (140) @(posedge clk);
    @(negedge clk);
    chk("t6 count before reset", 16'(cnt0), 16'd4);
    chk("t6 state data", 16'(dbg0), 16'd2);
    chk("t6 txd low data bit", 16'(txdW[0]), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("t6 txd on reset", 16'(txdW[0]), 16'd1);
    chk("t6 count on reset", 16'(cnt0), 16'd0);
    chk("t6 busy on reset", 16'(busyW[0]), 16'd0);
    chk("t6 ready on reset", 16'(wrReady[0]), 16'd1);
    chk("t6 state on reset", 16'(dbg0), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendCheck(0, 9'h0A5, mkFrame(9'h0A5, 8, 0, 1'b0, 1), 10, "t6 a5");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
